stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter WIDTH, default 6, SHALL set the stack-memory pointer width.
REQ-002 Parameter SIZE, default 64, SHALL set the entry count and SHALL equal 2**WIDTH.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 push  input  1  push din this cycle.
REQ-007 pop_cnt  input  2  number of entries to pop this cycle, 0..3.
REQ-008 din  input  16  data to push.
REQ-009 clr_err  input  1  clear the sticky error flags.
REQ-010 tos  output  16  top-of-stack value; 0 when depth < 1.
REQ-011 nos  output  16  next-of-stack value; 0 when depth < 2.
REQ-012 depth  output  WIDTH+1  current entry count, 0..SIZE.
REQ-013 empty / full  output  1 each  empty = (depth == 0); full = (depth == SIZE).
REQ-014 overflow / underflow  output  1 each  sticky error flags.
REQ-015 max_depth  output  WIDTH+1  high-water mark of depth since reset.
REQ-016 mem_dout_addr0 / mem_dout_addr1  output  WIDTH each  async-read addresses to the stack RAM.
REQ-017 mem_dout0 / mem_dout1  input  16 each  async-read data from the stack RAM.
REQ-018 we / mem_din_addr / mem_din  output  1 / WIDTH / 16  sync-write port to the stack RAM.

Function
REQ-019 Notation: d = depth register, p = pop_cnt, n = d - p + push, computed at WIDTH+2 bits, signed.
REQ-020 Legal op: d >= p and n <= SIZE; legal ops SHALL update depth to n at the next rising edge.
REQ-021 Underflow (d < p) SHALL leave the op ignored: depth unchanged, we = 0, underflow set at the next edge.
REQ-022 Overflow (d >= p and n > SIZE) SHALL leave the op ignored: depth unchanged, we = 0, overflow set at the next edge.
REQ-023 Push on a full stack with p >= 1 is legal (net <= 0) and SHALL NOT set overflow.
REQ-024 we SHALL be combinational = push AND op legal.
REQ-025 mem_din_addr SHALL be (d - p) mod SIZE; mem_din SHALL equal din.
REQ-026 A push with p > 0 SHALL overwrite the slot of the deepest popped entry (pop-then-push replace).
REQ-027 mem_dout_addr0 SHALL be (d - 1) mod SIZE; mem_dout_addr1 SHALL be (d - 2) mod SIZE.
REQ-028 Both read addresses SHALL be driven from the depth register only, never from current-cycle inputs.
REQ-029 tos SHALL equal mem_dout0 gated by d >= 1; nos SHALL equal mem_dout1 gated by d >= 2; both are combinational.
REQ-030 Read-after-write: a value pushed at edge N SHALL appear on tos in the cycle following edge N; there is no same-cycle bypass.
REQ-031 Sticky flags SHALL hold until rst or clr_err.
REQ-032 clr_err SHALL clear both flags at the next edge.
REQ-033 If a new error occurs in the same cycle as clr_err, the set SHALL win.
REQ-034 max_depth SHALL register max(max_depth, n) on each legal op.
REQ-035 Address arithmetic SHALL wrap modulo SIZE.
REQ-036 depth SHALL never leave 0..SIZE.

Reset
REQ-037 On rst at an edge, depth, max_depth, overflow and underflow SHALL become 0; rst has priority over all ops.
REQ-038 While rst is high, we SHALL be 0 regardless of push.
REQ-039 Stack RAM contents are not cleared by rst; tos and nos SHALL read 0 after reset because depth = 0.
REQ-040 Reset asserted mid-sequence SHALL discard any in-flight op issued in that cycle.

Verification
REQ-041 After reset: push 0x1111, then push 0x2222 -> depth = 2, tos = 0x2222, nos = 0x1111, we pulsed with addresses 0 then 1.
REQ-042 From depth 2 {0x1111, 0x2222}: push = 1, p = 2, din = 0x3333 -> mem_din_addr = 0, depth = 1, tos = 0x3333, nos = 0.
REQ-043 From an empty stack: pop_cnt = 1 -> underflow = 1, depth = 0, we = 0; next cycle clr_err = 1 -> underflow = 0.
REQ-044 Fill 64 pushes -> full = 1, max_depth = 64; a 65th push -> overflow = 1, depth = 64, we = 0; push with p = 1 -> legal, writes address 63.
REQ-045 At depth 3, assert rst with push = 1 in the same cycle -> we = 0; depth = 0, tos = 0, max_depth = 0 next cycle.
REQ-046 clr_err = 1 together with an underflowing pop -> underflow = 1 after the edge.

Source files
------------

// File: rtl/stack_ctrl.sv
// Hardware stack controller driving an external RAM (sync write, async read); depth/flags update one edge after the op.
// Never stalls: an illegal op (underflow/overflow) is dropped in its cycle and latched in a sticky flag.
module stack_ctrl #(
    parameter int WIDTH = 6,
    parameter int SIZE  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [1:0]       pop_cnt,
    input  logic [15:0]      din,
    input  logic             clr_err,
    output logic [15:0]      tos,
    output logic [15:0]      nos,
    output logic [WIDTH:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic [WIDTH:0]   max_depth,
    output logic [WIDTH-1:0] mem_dout_addr0,
    output logic [WIDTH-1:0] mem_dout_addr1,
    input  logic [15:0]      mem_dout0,
    input  logic [15:0]      mem_dout1,
    output logic             we,
    output logic [WIDTH-1:0] mem_din_addr,
    output logic [15:0]      mem_din
);
    localparam int XW = WIDTH + 2;
    localparam logic [XW-1:0] SIZE_X = XW'(SIZE);

    logic [WIDTH:0] depth_q, depth_d;
    logic [WIDTH:0] max_q, max_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    logic [XW-1:0]  d_x, p_x, base_x, n_x;
    logic           udf_op, ovf_op, legal;

    // Extra headroom bits so d - p + push never aliases before the range checks.
    always_comb begin
        d_x    = XW'(depth_q);
        p_x    = XW'(pop_cnt);
        base_x = d_x - p_x;
        n_x    = base_x + XW'(push);
        udf_op = (d_x < p_x);
        ovf_op = !udf_op && (n_x > SIZE_X);
        legal  = !udf_op && !ovf_op;
    end

    assign we           = push & legal & ~rst;
    assign mem_din_addr = base_x[WIDTH-1:0];
    assign mem_din      = din;

    assign mem_dout_addr0 = depth_q[WIDTH-1:0] - WIDTH'(1);
    assign mem_dout_addr1 = depth_q[WIDTH-1:0] - WIDTH'(2);

    assign tos = (depth_q >= (WIDTH+1)'(1)) ? mem_dout0 : 16'h0000;
    assign nos = (depth_q >= (WIDTH+1)'(2)) ? mem_dout1 : 16'h0000;

    assign depth     = depth_q;
    assign empty     = (depth_q == '0);
    assign full      = (depth_q == (WIDTH+1)'(SIZE));
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign max_depth = max_q;

    always_comb begin
        depth_d = depth_q;
        max_d   = max_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        // A fresh error in the clearing cycle still wins.
        if (ovf_op) ovf_d = 1'b1;
        if (udf_op) udf_d = 1'b1;
        if (legal) begin
            depth_d = n_x[WIDTH:0];
            if (n_x[WIDTH:0] > max_q) max_d = n_x[WIDTH:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack RAM (sync write, async read).
module tb_stack_ctrl;
    logic        clk = 1'b0;
    logic        rst, push, clr_err;
    logic [1:0]  pop_cnt;
    logic [15:0] din;
    logic [15:0] tos, nos, mem_dout0, mem_dout1, mem_din;
    logic [6:0]  depth, max_depth;
    logic        empty, full, overflow, underflow, we;
    logic [5:0]  mem_dout_addr0, mem_dout_addr1, mem_din_addr;

    int checks = 0;
    int failures = 0;

    logic [15:0] ram [64];

    always #5 clk = ~clk;

    always @(posedge clk) if (we) ram[mem_din_addr] <= mem_din;
    assign mem_dout0 = ram[mem_dout_addr0];
    assign mem_dout1 = ram[mem_dout_addr1];

    stack_ctrl #(.WIDTH(6), .SIZE(64)) dut (
        .clk(clk), .rst(rst), .push(push), .pop_cnt(pop_cnt), .din(din), .clr_err(clr_err),
        .tos(tos), .nos(nos), .depth(depth), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .max_depth(max_depth),
        .mem_dout_addr0(mem_dout_addr0), .mem_dout_addr1(mem_dout_addr1),
        .mem_dout0(mem_dout0), .mem_dout1(mem_dout1),
        .we(we), .mem_din_addr(mem_din_addr), .mem_din(mem_din)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop_cnt = 2'd0; clr_err = 1'b0; din = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); push = 1'b1; din = 16'hDEAD;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL we_in_reset got=%0h exp=0", we); end
        tick(); tick();
        rst = 1'b0; idle();
        #1;
        checks++; if (depth !== 7'd0) begin failures++; $display("FAIL rst_depth got=%0d exp=0", depth); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL rst_empty_full got=%b%b exp=10", empty, full); end
        checks++; if (tos !== 16'h0 || nos !== 16'h0) begin failures++; $display("FAIL rst_tos_nos got=%h/%h exp=0/0", tos, nos); end
        checks++; if (max_depth !== 7'd0) begin failures++; $display("FAIL rst_max got=%0d exp=0", max_depth); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", overflow, underflow); end
        checks++; if (mem_dout_addr0 !== 6'd63 || mem_dout_addr1 !== 6'd62) begin failures++; $display("FAIL rst_rdaddr got=%0d/%0d exp=63/62", mem_dout_addr0, mem_dout_addr1); end
    endtask

    task automatic test_push_two();
        push = 1'b1; din = 16'h1111;
        #1;
        checks++; if (we !== 1'b1 || mem_din_addr !== 6'd0) begin failures++; $display("FAIL push1_we_addr got=%b/%0d exp=1/0", we, mem_din_addr); end
        tick();
        din = 16'h2222;
        #1;
        checks++; if (tos !== 16'h1111) begin failures++; $display("FAIL push1_tos got=%h exp=1111", tos); end
        checks++; if (we !== 1'b1 || mem_din_addr !== 6'd1) begin failures++; $display("FAIL push2_we_addr got=%b/%0d exp=1/1", we, mem_din_addr); end
        tick();
        idle();
        #1;
        checks++; if (depth !== 7'd2) begin failures++; $display("FAIL push2_depth got=%0d exp=2", depth); end
        checks++; if (tos !== 16'h2222 || nos !== 16'h1111) begin failures++; $display("FAIL push2_tos_nos got=%h/%h exp=2222/1111", tos, nos); end
        checks++; if (mem_dout_addr0 !== 6'd1 || mem_dout_addr1 !== 6'd0) begin failures++; $display("FAIL push2_rdaddr got=%0d/%0d exp=1/0", mem_dout_addr0, mem_dout_addr1); end
    endtask

    task automatic test_replace();
        push = 1'b1; pop_cnt = 2'd2; din = 16'h3333;
        #1;
        checks++; if (we !== 1'b1 || mem_din_addr !== 6'd0) begin failures++; $display("FAIL repl_we_addr got=%b/%0d exp=1/0", we, mem_din_addr); end
        tick();
        idle();
        #1;
        checks++; if (depth !== 7'd1) begin failures++; $display("FAIL repl_depth got=%0d exp=1", depth); end
        checks++; if (tos !== 16'h3333 || nos !== 16'h0) begin failures++; $display("FAIL repl_tos_nos got=%h/%h exp=3333/0", tos, nos); end
        pop_cnt = 2'd1;
        tick();
        idle();
        #1;
        checks++; if (depth !== 7'd0 || tos !== 16'h0) begin failures++; $display("FAIL pop_to_empty got=%0d/%h exp=0/0", depth, tos); end
    endtask

    task automatic test_underflow();
        push = 1'b1; pop_cnt = 2'd1; din = 16'h4444;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL udf_we got=%b exp=0", we); end
        tick();
        idle();
        #1;
        checks++; if (underflow !== 1'b1 || overflow !== 1'b0 || depth !== 7'd0) begin failures++; $display("FAIL udf_set got=u%b o%b d%0d exp=u1 o0 d0", underflow, overflow, depth); end
        tick();
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_sticky got=%b exp=1", underflow); end
        clr_err = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_clr_vs_set();
        clr_err = 1'b1; pop_cnt = 2'd3;
        tick();
        idle();
        #1;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL clr_set_wins got=%b exp=1", underflow); end
        clr_err = 1'b1;
        tick();
        idle();
        #1;
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL clr_after got=%b exp=0", underflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) begin
            push = 1'b1; din = 16'h0100 + 16'(i);
            tick();
        end
        idle();
        #1;
        checks++; if (full !== 1'b1 || depth !== 7'd64) begin failures++; $display("FAIL fill_full got=%b/%0d exp=1/64", full, depth); end
        checks++; if (max_depth !== 7'd64) begin failures++; $display("FAIL fill_max got=%0d exp=64", max_depth); end
        checks++; if (tos !== 16'h013F || nos !== 16'h013E) begin failures++; $display("FAIL fill_tos_nos got=%h/%h exp=013f/013e", tos, nos); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
        push = 1'b1; din = 16'hAAAA;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL ovf_we got=%b exp=0", we); end
        tick();
        idle();
        #1;
        checks++; if (overflow !== 1'b1 || depth !== 7'd64 || tos !== 16'h013F) begin failures++; $display("FAIL ovf_set got=o%b d%0d t%h exp=o1 d64 t013f", overflow, depth, tos); end
        clr_err = 1'b1;
        tick();
        idle();
        push = 1'b1; pop_cnt = 2'd1; din = 16'hBEEF;
        #1;
        checks++; if (we !== 1'b1 || mem_din_addr !== 6'd63) begin failures++; $display("FAIL full_repl_we_addr got=%b/%0d exp=1/63", we, mem_din_addr); end
        tick();
        idle();
        #1;
        checks++; if (overflow !== 1'b0 || depth !== 7'd64 || tos !== 16'hBEEF) begin failures++; $display("FAIL full_repl got=o%b d%0d t%h exp=o0 d64 tbeef", overflow, depth, tos); end
        pop_cnt = 2'd3;
        tick();
        idle();
        #1;
        checks++; if (depth !== 7'd61 || tos !== 16'h013C || max_depth !== 7'd64) begin failures++; $display("FAIL pop3 got=d%0d t%h m%0d exp=d61 t013c m64", depth, tos, max_depth); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; din = 16'h0500 + 16'(i);
            tick();
        end
        checks++; if (depth !== 7'd3 || max_depth !== 7'd3) begin failures++; $display("FAIL mid_pre got=%0d/%0d exp=3/3", depth, max_depth); end
        rst = 1'b1; push = 1'b1; din = 16'h9999;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL mid_we got=%b exp=0", we); end
        tick();
        rst = 1'b0; idle();
        #1;
        checks++; if (depth !== 7'd0 || tos !== 16'h0 || max_depth !== 7'd0) begin failures++; $display("FAIL mid_after got=d%0d t%h m%0d exp=0/0/0", depth, tos, max_depth); end
        checks++; if (ram[3] === 16'h9999) begin failures++; $display("FAIL mid_ram_write got=%h exp=not 9999", ram[3]); end
    endtask

    task automatic test_back_to_back();
        push = 1'b1; din = 16'hA001;
        tick();
        push = 1'b1; pop_cnt = 2'd1; din = 16'hA002;
        #1;
        checks++; if (tos !== 16'hA001 || mem_din_addr !== 6'd0) begin failures++; $display("FAIL b2b_raw got=%h/%0d exp=a001/0", tos, mem_din_addr); end
        tick();
        push = 1'b1; pop_cnt = 2'd0; din = 16'hA003;
        tick();
        idle();
        #1;
        checks++; if (depth !== 7'd2 || tos !== 16'hA003 || nos !== 16'hA002 || max_depth !== 7'd2) begin failures++; $display("FAIL b2b got=d%0d t%h n%h m%0d exp=d2 ta003 na002 m2", depth, tos, nos, max_depth); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 16'h0000;
        test_reset();
        test_push_two();
        test_replace();
        test_underflow();
        test_clr_vs_set();
        test_fill();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
